// File: rtl/fixed_point_accumulator_if.sv
// Product/result stream bundle for fixed_point_accumulator: product val/rdy in, result val/rdy out.
// The master side feeds products and consumes results; the accumulator itself is the slave.
interface fixed_point_accumulator_if #(
    parameter int n = 32
);
    logic         recv_val;
    logic         recv_rdy;
    logic [n-1:0] a;
    logic         send_val;
    logic         send_rdy;
    logic [n-1:0] c;
    logic         sat;

    modport master (
        output recv_val, a, send_rdy,
        input  recv_rdy, send_val, c, sat
    );

    modport slave (
        input  recv_val, a, send_rdy,
        output recv_rdy, send_val, c, sat
    );
endinterface

// File: rtl/fixed_point_accumulator.sv
// Streaming accumulator: sums each group of m n-bit products and emits the n-bit result over val/rdy.
// Define FIXED_POINT_ACCUMULATOR_SATURATE_EN to clip results to the n-bit range (else modular wrap).
module fixed_point_accumulator #(
    parameter int n    = 32,
    parameter int m    = 4,
    parameter bit sign = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    fixed_point_accumulator_if.slave      bus
);
    localparam int CW = $clog2(m) + 1;
    localparam int W  = n + $clog2(m) + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic signed [W-1:0] acc_p0;
    logic signed [W-1:0] sum_p0;
    logic [CW-1:0]       count_p0;
    logic [n-1:0]        c_p1;
    logic                sat_p1;
    logic                accept;
    logic                handshake;
    logic                last;
    logic [n:0]          res;

    function automatic logic signed [W-1:0] extend(input logic [n-1:0] x);
        if (sign)
            return {{(W-n){x[n-1]}}, x};
        else
            return {{(W-n){1'b0}}, x};
    endfunction

    // Returns {clipped, value}.
    function automatic logic [n:0] round_sat(input logic signed [W-1:0] s);
`ifdef FIXED_POINT_ACCUMULATOR_SATURATE_EN
        if (sign) begin
            // In range exactly when every bit above the n-bit sign position matches it.
            if ((&s[W-1:n-1]) || !(|s[W-1:n-1]))
                return {1'b0, s[n-1:0]};
            else if (s[W-1])
                return {1'b1, 1'b1, {(n-1){1'b0}}};
            else
                return {1'b1, 1'b0, {(n-1){1'b1}}};
        end else begin
            if (|s[W-1:n])
                return {1'b1, {n{1'b1}}};
            else
                return {1'b0, s[n-1:0]};
        end
`else
        return {1'b0, s[n-1:0]};
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.recv_rdy = (state == ACCUM);
        bus.send_val = (state == SEND);
        accept       = bus.recv_val && (state == ACCUM);
        handshake    = bus.send_rdy && (state == SEND);
        last         = (count_p0 == CW'(m - 1));
        sum_p0       = acc_p0 + extend(bus.a);
        res          = round_sat(sum_p0);
        if (accept && last)
            state_nxt = SEND;
        else if (handshake)
            state_nxt = ACCUM;
    end

    // Stage p0: running sum; stage p1: result registered on the group's final accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0   <= '0;
            count_p0 <= '0;
            c_p1     <= '0;
            sat_p1   <= 1'b0;
        end else if (accept) begin
            acc_p0   <= sum_p0;
            count_p0 <= count_p0 + 1'b1;
            if (last) begin
                c_p1   <= res[n-1:0];
                sat_p1 <= res[n];
            end
        end else if (handshake) begin
            acc_p0   <= '0;
            count_p0 <= '0;
        end
    end

    assign bus.c   = c_p1;
    assign bus.sat = sat_p1;
endmodule

// File: doc/fixed_point_accumulator.md
# fixed_point_accumulator

Streaming fixed-point accumulator that sits directly downstream of the iterative fixed-point multiplier. It consumes a stream of n-bit products over a val/rdy interface and sums each group of m consecutive products, for example one dot product of length m. It emits the n-bit sum on a val/rdy output port. Binary-point position is preserved: inputs and output share the same Q format, and no shifting is applied.

## Interface
- n, 32, data width of each product and of the result
- m, 4, number of products summed per result (m ≥ 1)
- sign, 1, 1 = two's-complement operands and result; 0 = unsigned
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- recv_val  input  1  product valid
- recv_rdy  output  1  block can accept a product
- a  input  n  product to accumulate
- send_val  output  1  result valid
- send_rdy  input  1  consumer accepts result
- c  output  n  accumulated result
- sat  output  1  result was clipped; valid while send_val = 1

## Operation
- Accumulator acc is W = n + $clog2(m) + 1 bits wide.
- Input extension: sign-extended when sign = 1, zero-extended when sign = 0. Extended a is added to acc.
- count is a $clog2(m)+1-bit register holding the number of products accepted in the current group.
- States:
  - ACCUM:
    - recv_rdy = 1, send_val = 0.
    - On recv_val & recv_rdy: acc ← acc + ext(a), count ← count + 1.
    - If that accept makes count reach m: go to SEND, and register c and sat from the post-add sum.
  - SEND:
    - recv_rdy = 0, send_val = 1.
    - c and sat are held stable.
    - recv_val is ignored; no product is consumed.
    - On send_val & send_rdy: acc ← 0, count ← 0, go to ACCUM.
- recv_rdy and send_val are decoded directly from the state register. They are never combinationally dependent on recv_val or send_rdy.
- Result formation, saturation compiled in: see Configuration.
- Arithmetic overflow of acc is impossible for any m within the W-bit width.

## Timing
- Reset:
  - state = ACCUM, acc = 0, count = 0, c = 0, sat = 0.
  - Outputs after the reset edge: recv_rdy = 1, send_val = 0.
  - Reset asserted mid-group or in SEND discards partial sums and any pending result.
- Accept rate: one product per cycle in ACCUM.
- Latency: send_val rises on the clock edge that accepts the m-th product, so it is visible in the following cycle.
- Throughput:
  - Minimum m + 1 cycles per result, because SEND lasts at least one cycle.
  - The first product of the next group can be accepted the cycle after the send handshake.
- Backpressure: send_val, c and sat stay constant until send_rdy is sampled high. There is no timeout.
- m = 1: every accepted product goes straight to SEND, giving at most one product per 2 cycles.
- recv_val while in SEND: not consumed. The upstream multiplier holds its output until recv_rdy returns.

## Configuration
- FIXED_POINT_ACCUMULATOR_SATURATE_EN, defined:
  - Result is clipped to the n-bit range.
  - sign = 1: range is [-2^(n-1), 2^(n-1)-1].
  - sign = 0: range is [0, 2^n-1].
  - sat = 1 when clipping occurred.
- Not defined:
  - c = acc[n-1:0], i.e. modular wrap.
  - sat is tied to 0.
  - The saturation comparators are not synthesized.

## Test plan
All scenarios use n = 8, m = 4, sign = 1 (Q4.4) unless stated otherwise.
- Reset for 2 cycles → send_val = 0, recv_rdy = 1, c = 0x00, sat = 0.
- Products 0x10, 0x20, 0x08, 0x04 on consecutive cycles, send_rdy = 1 → send_val high the cycle after the 4th accept; c = 0x3C, sat = 0; recv_rdy = 1 again the cycle after the handshake.
- Four products of 0x60 (sum 0x180):
  - Macro defined → c = 0x7F, sat = 1.
  - Macro undefined → c = 0x80, sat = 0.
- Four products of 0xC0 (sum -256):
  - Macro defined → c = 0x80, sat = 1.
  - Macro undefined → c = 0x00.
  - With sign = 0, four products of 0x50 and macro defined → c = 0xFF, sat = 1.
- Result pending, send_rdy low for 5 cycles while recv_val = 1 with a = 0x11 → recv_rdy = 0, c and send_val stable throughout, no product consumed. Then send_rdy = 1 → the next group sums fresh; four products of 0x01 give c = 0x04.
- Reset asserted after 2 of 4 products → the next 4 products 0x01, 0x02, 0x03, 0x04 give c = 0x0A, with no residue from the partial group.
